// File: rtl/von_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 4-bit von Neumann datapath.
// Moore state outputs plus ack-gated strobes in the memory phases.
module von_ctrl_fsm #(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [OP_W-1:0] ir_op,
    input  logic            zero_flag,
    input  logic            mem_ack,
    output logic            pc_clear,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_load,
    output logic            mar_sel,
    output logic            ir_load,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            acc_load,
    output logic [1:0]      alu_op,
    output logic            halted,
    output logic [1:0]      err
);

    typedef enum logic [2:0] {
        S_RST, S_F1, S_F2, S_DEC, S_EX, S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    localparam logic [1:0] ERR_ILL = 2'b01;
    localparam logic [1:0] ERR_BUS = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic [1:0] r_err;
    logic [1:0] w_err_nxt;
    logic       w_timeout;
    logic       w_is_sta;

    assign w_timeout = (r_wait_cnt == 8'(TIMEOUT));
    assign w_is_sta  = (ir_op == OP_STA);
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state    <= S_RST;
            r_wait_cnt <= 8'd0;
            r_err      <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        w_err_nxt  = r_err;
        pc_clear   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        mar_sel    = 1'b0;
        ir_load    = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        acc_load   = 1'b0;
        alu_op     = 2'b00;
        halted     = 1'b0;
        case (r_state)
            S_RST: begin
                pc_clear = 1'b1;
                w_next   = S_F1;
            end
            S_F1: begin
                mar_load   = 1'b1;
                w_wait_nxt = 8'd0;
                w_next     = S_F2;
            end
            S_F2: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    w_wait_nxt = 8'd0;
                    w_next     = S_DEC;
                end else if (w_timeout) begin
                    w_err_nxt = ERR_BUS;
                    w_next    = S_HALT;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_DEC: begin
                w_wait_nxt = 8'd0;
                case (ir_op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        mar_sel  = 1'b1;
                        mar_load = 1'b1;
                        w_next   = S_EX;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        w_next  = S_F1;
                    end
                    OP_JZ: begin
                        pc_load = zero_flag;
                        w_next  = S_F1;
                    end
                    OP_NOP: w_next = S_F1;
                    OP_HLT: w_next = S_HALT;
                    default: begin
                        w_err_nxt = ERR_ILL;
                        w_next    = S_HALT;
                    end
                endcase
            end
            S_EX: begin
                // Only a store writes; every other op here reads an operand.
                if (w_is_sta) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    if (ir_op == OP_ADD) alu_op = 2'b01;
                    else if (ir_op == OP_SUB) alu_op = 2'b10;
                end
                if (mem_ack) begin
                    acc_load   = !w_is_sta;
                    w_wait_nxt = 8'd0;
                    w_next     = S_F1;
                end else if (w_timeout) begin
                    w_err_nxt = ERR_BUS;
                    w_next    = S_HALT;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_RST;
        endcase
    end

endmodule
